// File: rtl/aec_result_fmt_if.sv
// rtl/aec_result_fmt_if.sv - result-in / character-out stream bundle for aec_result_fmt
// hex_sel exists only when AEC_FMT_HEX_EN is defined.
interface aec_result_fmt_if;
   logic       in_valid;
   logic [6:0] in_result;
`ifdef AEC_FMT_HEX_EN
   logic       hex_sel;
`endif
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_char;
   logic       out_last;

`ifdef AEC_FMT_HEX_EN
   modport master (output in_valid, in_result, hex_sel, out_ready,
                   input  out_valid, out_char, out_last);
   modport slave  (input  in_valid, in_result, hex_sel, out_ready,
                   output out_valid, out_char, out_last);
`else
   modport master (output in_valid, in_result, out_ready,
                   input  out_valid, out_char, out_last);
   modport slave  (input  in_valid, in_result, out_ready,
                   output out_valid, out_char, out_last);
`endif
endinterface

// File: rtl/aec_result_fmt.sv
// rtl/aec_result_fmt.sv - converts 7-bit results to ASCII decimal text on a byte stream
// Optional two-digit lowercase hex mode when AEC_FMT_HEX_EN is defined.
module aec_result_fmt #(
   parameter logic [7:0] TERM_CHAR = 8'h0A,
   parameter bit         EMIT_TERM = 1'b1,
   parameter int         DROP_W    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   aec_result_fmt_if.slave   io,
   output logic              busy,
   output logic [DROP_W-1:0] drop_cnt
);
   typedef enum logic [1:0] {IDLE, CONV, EMIT, TERM} state_t;

   state_t            state_q, state_d;
   logic [18:0]       dd_q, dd_d;     // {hundreds, tens, ones, binary}
   logic [2:0]        cnt_q, cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic [3:0]        hund, tens, ones, digit;
   logic              valid_w, xfer;
`ifdef AEC_FMT_HEX_EN
   logic              hex_q, hex_d;
`endif

   function automatic logic [18:0] dd_step(input logic [18:0] v);
      logic [18:0] t;
      t = v;
      for (int i = 0; i < 3; i++) begin
         if (t[7+4*i +: 4] >= 4'd5) t[7+4*i +: 4] = t[7+4*i +: 4] + 4'd3;
      end
      return {t[17:0], 1'b0};
   endfunction

   assign hund    = dd_q[18:15];
   assign tens    = dd_q[14:11];
   assign ones    = dd_q[10:7];
   assign valid_w = (state_q == EMIT) || (state_q == TERM);
   assign xfer    = valid_w && io.out_ready;

   always_comb begin
      digit = ones;
      case (idx_q)
         2'd0:    digit = hund;
         2'd1:    digit = tens;
         default: digit = ones;
      endcase
   end

   // Digits above 9 only occur in hex mode and map to 'a'..'f'.
   always_comb begin
      io.out_char = 8'h00;
      if (state_q == TERM)
         io.out_char = TERM_CHAR;
      else if (state_q == EMIT)
         io.out_char = (digit < 4'd10) ? 8'h30 + {4'd0, digit} : 8'h57 + {4'd0, digit};
   end

   assign io.out_valid = valid_w;
   assign io.out_last  = (state_q == TERM) || (state_q == EMIT && idx_q == 2'd2 && !EMIT_TERM);
   assign busy         = (state_q != IDLE);
   assign drop_cnt     = drop_q;

   always_comb begin
      state_d = state_q;
      dd_d    = dd_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      drop_d  = drop_q;
`ifdef AEC_FMT_HEX_EN
      hex_d   = hex_q;
`endif
      if (io.in_valid && state_q != IDLE && drop_q != {DROP_W{1'b1}})
         drop_d = drop_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (io.in_valid) begin
               state_d = CONV;
               dd_d    = {12'd0, io.in_result};
               cnt_d   = 3'd0;
`ifdef AEC_FMT_HEX_EN
               hex_d   = io.hex_sel;
               // Hex nibbles go straight into the tens/ones slots; the
               // preset count makes CONV last a single cycle.
               if (io.hex_sel) begin
                  dd_d  = {4'd0, 1'b0, io.in_result[6:4], io.in_result[3:0], 7'd0};
                  cnt_d = 3'd7;
               end
`endif
            end
         end
         CONV: begin
            if (cnt_q == 3'd7) begin
               state_d = EMIT;
               idx_d   = (hund != 4'd0) ? 2'd0 : (tens != 4'd0) ? 2'd1 : 2'd2;
`ifdef AEC_FMT_HEX_EN
               if (hex_q) idx_d = 2'd1;
`endif
            end else begin
               dd_d  = dd_step(dd_q);
               cnt_d = cnt_q + 3'd1;
            end
         end
         EMIT: begin
            if (xfer) begin
               if (idx_q == 2'd2) state_d = EMIT_TERM ? TERM : IDLE;
               else               idx_d   = idx_q + 2'd1;
            end
         end
         TERM: begin
            if (xfer) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dd_q    <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         drop_q  <= '0;
`ifdef AEC_FMT_HEX_EN
         hex_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         dd_q    <= dd_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         drop_q  <= drop_d;
`ifdef AEC_FMT_HEX_EN
         hex_q   <= hex_d;
`endif
      end
   end
endmodule

// File: tb/tb_aec_result_fmt.sv
// tb/tb_aec_result_fmt.sv - self-checking bench for aec_result_fmt
// Table vectors, hand-written corner sequences and a randomized string model.
module tb_aec_result_fmt;
   localparam logic [7:0] TERM = 8'h0A;

   typedef struct {
      logic [6:0]  val;
      bit          hx;
      int          rmode;
      int          len;
      logic [31:0] chars;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       busy;
   logic [3:0] drop_cnt;
   int         checks = 0;
   int         failures = 0;
   int         exp_drop = 0;
   logic [7:0] exp_q[$];

   aec_result_fmt_if io();

   aec_result_fmt dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .io       (io),
      .busy     (busy),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   function automatic void build_exp(input int v, input bit hx);
      string s;
      logic [7:0] b8;
      b8 = 8'(v);
      s = hx ? $sformatf("%02h", b8) : $sformatf("%0d", v);
      exp_q = {};
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      exp_q.push_back(TERM);
   endfunction

   task automatic drive_drop(input int dmode, input int k);
      if (dmode == 2 || (dmode == 1 && k == 2)) begin
         io.in_valid  = 1'b1;
         io.in_result = 7'($urandom);
         exp_drop     = (exp_drop < 15) ? exp_drop + 1 : 15;
      end else begin
         io.in_valid = 1'b0;
      end
   endtask

   task automatic run_frame(input logic [6:0] v, input bit hx, input int rmode, input int dmode);
      int k, got, budget, stall;
      logic [7:0] pc;
      logic pl;
      bit held;
      @(negedge clk);
      io.in_valid  = 1'b1;
      io.in_result = v;
`ifdef AEC_FMT_HEX_EN
      io.hex_sel   = hx;
`endif
      @(negedge clk);
      io.in_valid = 1'b0;
      check("busy_at_e0", 32'(busy), 32'd1);
      k = 0;
      while (!io.out_valid && k < 40) begin
         drive_drop(dmode, k);
         @(negedge clk);
         k++;
      end
      check("latency", 32'(k), hx ? 32'd1 : 32'd8);
      got = 0; budget = 0; held = 0; stall = 0; pc = '0; pl = 1'b0;
      while (got < exp_q.size() && budget < 200) begin
         check("valid_held", 32'(io.out_valid), 32'd1);
         if (!io.out_valid) break;
         if (held) begin
            check("char_stable", 32'(io.out_char), 32'(pc));
            check("last_stable", 32'(io.out_last), 32'(pl));
         end
         case (rmode)
            0:       io.out_ready = 1'b1;
            1:       io.out_ready = ($urandom_range(0, 3) != 0);
            default: begin io.out_ready = (stall >= 5); stall++; end
         endcase
         drive_drop(dmode, 99);
         if (io.out_ready) begin
            check("char", 32'(io.out_char), 32'(exp_q[got]));
            check("last", 32'(io.out_last), 32'(got == exp_q.size() - 1));
            got++;
         end
         held = !io.out_ready;
         pc   = io.out_char;
         pl   = io.out_last;
         @(negedge clk);
         budget++;
      end
      io.in_valid  = 1'b0;
      io.out_ready = 1'b0;
      check("frame_done", 32'(got), 32'(exp_q.size()));
      check("busy_after", 32'(busy), 32'd0);
      check("valid_after", 32'(io.out_valid), 32'd0);
      check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
   endtask

   initial begin
      vec_t tbl[8];
      int   k;
      bit   hx;
      rst_n        = 1'b0;
      io.in_valid  = 1'b0;
      io.in_result = '0;
      io.out_ready = 1'b0;
`ifdef AEC_FMT_HEX_EN
      io.hex_sel   = 1'b0;
`endif
      #12;
      check("rst_valid", 32'(io.out_valid), 32'd0);
      check("rst_char", 32'(io.out_char), 32'd0);
      check("rst_last", 32'(io.out_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      tbl[0] = '{7'd123, 1'b0, 0, 4, 32'h3132330A};
      tbl[1] = '{7'd0,   1'b0, 0, 2, 32'h300A0000};
      tbl[2] = '{7'd7,   1'b0, 0, 2, 32'h370A0000};
      tbl[3] = '{7'd45,  1'b0, 2, 3, 32'h34350A00};
      tbl[4] = '{7'd100, 1'b0, 1, 4, 32'h3130300A};
      tbl[5] = '{7'd127, 1'b0, 0, 4, 32'h3132370A};
      tbl[6] = '{7'd10,  1'b0, 1, 3, 32'h31300A00};
      tbl[7] = '{7'd99,  1'b0, 0, 3, 32'h39390A00};
      for (int i = 0; i < 8; i++) begin
         exp_q = {};
         for (int j = 0; j < tbl[i].len; j++) exp_q.push_back(tbl[i].chars[31-8*j -: 8]);
         run_frame(tbl[i].val, tbl[i].hx, tbl[i].rmode, 0);
      end

`ifdef AEC_FMT_HEX_EN
      tbl[0] = '{7'd127, 1'b1, 0, 3, 32'h37660A00};
      tbl[1] = '{7'd5,   1'b1, 0, 3, 32'h30350A00};
      tbl[2] = '{7'd10,  1'b1, 1, 3, 32'h30610A00};
      tbl[3] = '{7'd0,   1'b1, 2, 3, 32'h30300A00};
      for (int i = 0; i < 4; i++) begin
         exp_q = {};
         for (int j = 0; j < tbl[i].len; j++) exp_q.push_back(tbl[i].chars[31-8*j -: 8]);
         run_frame(tbl[i].val, tbl[i].hx, tbl[i].rmode, 0);
      end
`endif

      // Drops: a single one, then enough to saturate the counter.
      build_exp(123, 1'b0);
      run_frame(7'd123, 1'b0, 0, 1);
      build_exp(77, 1'b0);
      run_frame(7'd77, 1'b0, 1, 2);
      build_exp(50, 1'b0);
      run_frame(7'd50, 1'b0, 0, 2);
      check("drop_saturated", 32'(drop_cnt), 32'd15);

      // Asynchronous reset while "2" of 123 is pending.
      @(negedge clk);
      io.in_valid  = 1'b1;
      io.in_result = 7'd123;
`ifdef AEC_FMT_HEX_EN
      io.hex_sel   = 1'b0;
`endif
      @(negedge clk);
      io.in_valid = 1'b0;
      k = 0;
      while (!io.out_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("rst_seq_first", 32'(io.out_char), 32'h31);
      io.out_ready = 1'b1;
      @(negedge clk);
      io.out_ready = 1'b0;
      check("rst_seq_second", 32'(io.out_char), 32'h32);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(io.out_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_last", 32'(io.out_last), 32'd0);
      check("midrst_drop", 32'(drop_cnt), 32'd0);
      exp_drop = 0;
      @(negedge clk);
      rst_n = 1'b1;
      build_exp(9, 1'b0);
      run_frame(7'd9, 1'b0, 0, 0);

      for (int n = 0; n < 30; n++) begin
         k  = $urandom_range(0, 127);
         hx = 1'b0;
`ifdef AEC_FMT_HEX_EN
         hx = 1'($urandom_range(0, 1));
`endif
         build_exp(k, hx);
         run_frame(7'(k), hx, 1, ($urandom_range(0, 3) == 0) ? 2 : 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
